// File: rtl/x25519_row_seq_if.sv
// ---------------------------------------------------------------------------
// x25519_row_seq_if: front-end and datapath signals of the X25519 row
// sequencer, bundled for connection to x25519_row_seq.
//   Front end : start, a_in, b_in, c_in (to sequencer)
//               ready, busy, done, res (from sequencer)
//   Datapath  : dp_rs1, dp_rs2, dp_rs3, dp_op_maddlu, dp_op_maddhu (from seq)
//               dp_rd (to sequencer, combinational from the operands)
// Modports: slave = sequencer side, master = environment (front end + MAC).
// ---------------------------------------------------------------------------
interface x25519_row_seq_if #(
  parameter int unsigned NLIMB = 4
);
  localparam int unsigned LW = 64;

  logic                      start;
  logic [NLIMB*LW-1:0]       a_in;
  logic [LW-1:0]             b_in;
  logic [NLIMB*LW-1:0]       c_in;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic [(NLIMB+1)*LW-1:0]   res;
  logic [LW-1:0]             dp_rs1;
  logic [LW-1:0]             dp_rs2;
  logic [LW-1:0]             dp_rs3;
  logic                      dp_op_maddlu;
  logic                      dp_op_maddhu;
  logic [LW-1:0]             dp_rd;

  modport slave (
    input  start, a_in, b_in, c_in, dp_rd,
    output ready, busy, done, res,
    output dp_rs1, dp_rs2, dp_rs3, dp_op_maddlu, dp_op_maddhu
  );

  modport master (
    output start, a_in, b_in, c_in, dp_rd,
    input  ready, busy, done, res,
    input  dp_rs1, dp_rs2, dp_rs3, dp_op_maddlu, dp_op_maddhu
  );
endinterface

// File: rtl/x25519_row_seq.sv
// ---------------------------------------------------------------------------
// x25519_row_seq: computes one row R = A*b + C of a multi-limb X25519
// multiply by time-sharing one 64-bit multiply-add unit (maddlu/maddhu).
// Each limb issues a low-half op then a high-half op; the carry is
// propagated internally. Result is NLIMB+1 limbs, little-endian.
// Ports:
//   cop_clk  clock, rising edge
//   cop_rst  synchronous active-low reset
//   bus      x25519_row_seq_if.slave (front-end handshake, operands,
//            result, and the multiply-add datapath operands/result)
// Optional build macro: X25519_SEQ_PIPE_EN registers dp_rd for one cycle
// before use, adding LOW/HIW wait states (each op held for 2 cycles).
// ---------------------------------------------------------------------------
module x25519_row_seq #(
  parameter int unsigned NLIMB = 4
) (
  input  logic                cop_clk,
  input  logic                cop_rst,
  x25519_row_seq_if.slave     bus
);

  localparam int unsigned LW = 64;
  localparam int unsigned IW = 3;

`ifdef X25519_SEQ_PIPE_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LO = 3'd1, S_HI = 3'd2, S_DONE = 3'd3,
    S_LOW  = 3'd4, S_HIW = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LO = 3'd1, S_HI = 3'd2, S_DONE = 3'd3
  } state_t;
`endif

  state_t                  state_q;
  logic [NLIMB-1:0][LW-1:0] a_q;
  logic [NLIMB-1:0][LW-1:0] c_q;
  logic [LW-1:0]           b_q;
  logic [IW-1:0]           i_q;
  logic [LW-1:0]           lo_q;
  logic [LW-1:0]           carry_q;
  logic [NLIMB:0][LW-1:0]  res_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic [LW-1:0]           rs1_q;
  logic [LW-1:0]           rs2_q;
  logic [LW-1:0]           rs3_q;
  logic                    maddlu_q;
  logic                    maddhu_q;

  // Datapath result as consumed by the sequencer (registered when piped)
  logic [LW-1:0] rd_use;
`ifdef X25519_SEQ_PIPE_EN
  logic [LW-1:0] rd_q;
  assign rd_use = rd_q;
`else
  assign rd_use = bus.dp_rd;
`endif

  // Carry chain: hi + (lo + carry) overflow; the add never exceeds 64 bits
  logic [LW:0]     sum_d;
  logic [LW-1:0]   carry_d;
  logic [IW-1:0]   i_nxt_d;
  logic            last_d;
  logic [LW-1:0]   a_nxt_d;
  logic [LW-1:0]   c_nxt_d;

  assign sum_d   = {1'b0, lo_q} + {1'b0, carry_q};
  assign carry_d = rd_use + LW'(sum_d[LW]);
  assign i_nxt_d = i_q + IW'(1);
  assign last_d  = (i_q == IW'(NLIMB - 1));

  // Operand limbs for the next limb index
  always_comb begin
    a_nxt_d = '0;
    c_nxt_d = '0;
    for (int k = 0; k < int'(NLIMB); k++) begin
      if (i_nxt_d == IW'(k)) begin
        a_nxt_d = a_q[k];
        c_nxt_d = c_q[k];
      end
    end
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge cop_clk) begin
    if (!cop_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      c_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      lo_q     <= '0;
      carry_q  <= '0;
      res_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      maddlu_q <= 1'b0;
      maddhu_q <= 1'b0;
`ifdef X25519_SEQ_PIPE_EN
      rd_q     <= '0;
`endif
    end else begin
`ifdef X25519_SEQ_PIPE_EN
      rd_q <= bus.dp_rd;
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q      <= bus.a_in;
            b_q      <= bus.b_in;
            c_q      <= bus.c_in;
            i_q      <= '0;
            carry_q  <= '0;
            res_q    <= '0;
            state_q  <= S_LO;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            maddlu_q <= 1'b1;
            maddhu_q <= 1'b0;
            rs1_q    <= bus.a_in[LW-1:0];
            rs2_q    <= bus.b_in;
            rs3_q    <= bus.c_in[LW-1:0];
          end else begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            maddlu_q <= 1'b0;
            maddhu_q <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
          end
        end

`ifdef X25519_SEQ_PIPE_EN
        // Wait for the registered low-half result; operands held
        S_LO: state_q <= S_LOW;
        // Wait for the registered high-half result; operands held
        S_HI: state_q <= S_HIW;
`endif

        // Capture the low half and issue the high half on the same operands
`ifdef X25519_SEQ_PIPE_EN
        S_LOW: begin
`else
        S_LO: begin
`endif
          lo_q     <= rd_use;
          state_q  <= S_HI;
          maddlu_q <= 1'b0;
          maddhu_q <= 1'b1;
        end

        // Commit limb i, update carry, then next limb or finish
`ifdef X25519_SEQ_PIPE_EN
        S_HIW: begin
`else
        S_HI: begin
`endif
          for (int k = 0; k < int'(NLIMB); k++) begin
            if (i_q == IW'(k)) res_q[k] <= sum_d[LW-1:0];
          end
          carry_q <= carry_d;
          if (last_d) begin
            res_q[NLIMB] <= carry_d;
            state_q  <= S_DONE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            maddlu_q <= 1'b0;
            maddhu_q <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
          end else begin
            i_q      <= i_nxt_d;
            state_q  <= S_LO;
            maddlu_q <= 1'b1;
            maddhu_q <= 1'b0;
            rs1_q    <= a_nxt_d;
            rs2_q    <= b_q;
            rs3_q    <= c_nxt_d;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          maddlu_q <= 1'b0;
          maddhu_q <= 1'b0;
          rs1_q    <= '0;
          rs2_q    <= '0;
          rs3_q    <= '0;
        end
      endcase
    end
  end

  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.res          = res_q;
  assign bus.dp_rs1       = rs1_q;
  assign bus.dp_rs2       = rs2_q;
  assign bus.dp_rs3       = rs3_q;
  assign bus.dp_op_maddlu = maddlu_q;
  assign bus.dp_op_maddhu = maddhu_q;

endmodule

// File: doc/x25519_row_seq.md
# x25519_row_seq

Multi-cycle sequencer that computes one row of a multi-limb X25519 multiply, R = A·b + C, by time-sharing a single 64-bit multiply-add datapath that provides maddlu/maddhu. It sits between a register-file-facing front end, which supplies NLIMB-limb operands, and the combinational multiply-add unit. It issues one low-half and one high-half operation per limb and propagates the carry internally. Result is NLIMB+1 limbs, little-endian (limb 0 = bits [63:0]).

## Interface
- NLIMB, 4, number of 64-bit limbs in A and C (2..8)
- cop_clk  in  1  clock; all state updates on rising edge
- cop_rst  in  1  reset, synchronous, active-low
- start  in  1  request; accepted when ready=1
- a_in  in  NLIMB*64  multiplicand A, sampled on accept
- b_in  in  64  scalar limb b, sampled on accept
- c_in  in  NLIMB*64  addend C, sampled on accept
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  one-cycle pulse, high in DONE
- res  out  (NLIMB+1)*64  result, valid from done; held until next accept or reset
- dp_rs1  out  64  datapath operand a_i
- dp_rs2  out  64  datapath operand b
- dp_rs3  out  64  datapath addend c_i
- dp_op_maddlu  out  1  select low-half op
- dp_op_maddhu  out  1  select high-half op
- dp_rd  in  64  datapath result; combinational from dp_rs*/dp_op_*

## Operation
- Internal state: latched A, b, C; limb index i (3 bits); lo register (64); carry register (64); res register.
- FSM states: IDLE, LO, HI, DONE. With X25519_SEQ_PIPE_EN, two more states: LOW, HIW.
- IDLE/DONE + start: latch operands, i=0, carry=0, clear res, go to LO. Without start, DONE returns to IDLE.
- LO: dp_op_maddlu=1, rs1=a_i, rs2=b, rs3=c_i. lo ← dp_rd. Next state: HI (or LOW when piped).
- HI: dp_op_maddhu=1, same operands. Sum = lo + carry (65-bit). res limb i ← sum[63:0]. carry ← dp_rd + sum[64].
  - If i=NLIMB-1: res limb NLIMB ← new carry; go to DONE.
  - Otherwise: i ← i+1; go to LO.
- Carry arithmetic never overflows 64 bits: hi=2^64−1 implies lo=0, so sum[64]=0. No saturation logic is required.
- dp_op_* are mutually exclusive. Outside LO/HI/LOW/HIW: dp_op_*=0 and dp_rs*=0.
- start while busy: ignored; no effect on state or latched operands.
- Reset (cop_rst=0, including mid-operation): state→IDLE, i=0, lo=0, carry=0, res=0. Latched operands are cleared.
- Reset values of outputs: ready=1, busy=0, done=0, res=0, dp_rs1/2/3=0, dp_op_maddlu=0, dp_op_maddhu=0.

## Timing
- Start accepted at edge 0.
- Without pipe: LO in cycles 1,3,…; HI in cycles 2,4,…; done in cycle 2·NLIMB+1 (9 for NLIMB=4).
- With pipe: each op takes 2 cycles. Done in cycle 4·NLIMB+1 (17 for NLIMB=4).
- A start in the DONE cycle is accepted. Back-to-back throughput is one row per 2·NLIMB+1 cycles (4·NLIMB+1 piped).
- res changes only on accept (cleared), on HI writes, and on reset.

## Configuration
- X25519_SEQ_PIPE_EN defined:
  - dp_rd is registered for one cycle before use.
  - LO→LOW→HI→HIW sequence; lo/carry/res updates occur in LOW/HIW from the registered value.
  - Operands and op select are held stable across each op's 2 cycles.
- Undefined: dp_rd is consumed in the same cycle it is issued; no LOW/HIW states exist.

## Test plan
- Basic row: NLIMB=4, A limbs all 1, b=2, C=0. Expect res limbs {2,2,2,2,0}, done at cycle 9 (17 piped), done high for exactly 1 cycle.
- Worst-case carry: all A limbs, all C limbs and b = 0xFFFF_FFFF_FFFF_FFFF. Expect res limb0=0 and limbs1..4=0xFFFF_FFFF_FFFF_FFFF.
- Busy-ignore: start a row, pulse start with different operands at cycle 3. Expect the result of the first operands only and no extra done pulse.
- Reset mid-op: assert cop_rst=0 at cycle 4. On the next cycle expect busy=0, ready=1, res=0, dp_op_*=0. A following start with the basic-row operands yields {2,2,2,2,0}.
- Back-to-back: start in the DONE cycle with b=3, A limbs=1, C limbs=5. Expect second done 9 cycles later (17 piped) and res {8,8,8,8,0}.
- Datapath protocol: monitor every cycle. dp_op_maddlu and dp_op_maddhu are never both 1, and there are exactly NLIMB of each per row in order LO,HI per limb. With the pipe enabled, operands are stable across each 2-cycle op.
